dig_scan_ctrl: RTL and testbench



---
 rtl/dig_pkg.sv | 22 ++
 rtl/seg7_decode.sv | 14 +
 rtl/dig_scan_ctrl.sv | 106 ++++++++++
 tb/tb_dig_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dig_pkg.sv
// dig_pkg: register map, CTRL reset value and segment table for the digit scan controller
package dig_pkg;

    localparam logic [11:0] DIG_DATA_OFS = 12'h000;
    localparam logic [11:0] DIG_CTRL_OFS = 12'h004;

    // {RUN, DP mask, enable mask}
    localparam logic [16:0] DIG_CTRL_RST = 17'h1_00FF;

    // Active-low {A,B,C,D,E,F,G} for hex digits 0..F
    localparam logic [6:0] DIG_SEG_TAB [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    typedef enum logic [1:0] {
        PH_OFF,
        PH_BLANK,
        PH_DRIVE
    } dig_phase_e;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: hex nibble to active-low {A..G} segment pattern
module seg7_decode
    import dig_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // table lookup
    always_comb begin
        seg = DIG_SEG_TAB[nib];
    end

endmodule

// File: rtl/dig_scan_ctrl.sv
// dig_scan_ctrl: bus-mapped 8-digit 7-segment scan controller; DIG_LZB_EN enables leading-zero blanking
module dig_scan_ctrl
    import dig_pkg::*;
#(
    parameter int SCAN_DIV  = 25000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] addr,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_data
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    logic [31:0]      data_q, data_d, sh_data_q, sh_data_d;
    logic [7:0]       mask_q, mask_d, dp_q, dp_d, sh_dp_q, sh_dp_d;
    logic [7:0]       dig_en_q, dig_en_d, dig_data_q, dig_data_d;
    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             wr_data, wr_ctrl, keep, wrap, frame_end, reload, lzb_ok, lit;
    logic [3:0]       nib;
    logic [6:0]       seg;
    dig_phase_e       phase;

    seg7_decode u_dec (
        .nib (nib),
        .seg (seg)
    );

    // architectural register writes and combinational readback
    always_comb begin
        wr_data = wen && addr == DIG_DATA_OFS;
        wr_ctrl = wen && addr == DIG_CTRL_OFS;
        data_d  = wr_data ? wdata : data_q;
        mask_d  = wr_ctrl ? wdata[7:0] : mask_q;
        dp_d    = wr_ctrl ? wdata[15:8] : dp_q;
        run_d   = wr_ctrl ? wdata[16] : run_q;
        rdata   = addr == DIG_DATA_OFS ? data_q :
                  addr == DIG_CTRL_OFS ? {15'b0, run_q, dp_q, mask_q} : 32'b0;
    end

    // slot counters and frame-end / restart shadow reload
    always_comb begin
        keep      = run_q && run_d;
        wrap      = cnt_q == CNT_MAX;
        frame_end = run_q && wrap && idx_q == 3'd7;
        cnt_d     = !keep || wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d     = !keep ? 3'd0 : wrap ? idx_q + 3'd1 : idx_q;
        reload    = frame_end || (run_d && !run_q);
        sh_data_d = reload ? data_d : sh_data_q;
        sh_dp_d   = reload ? dp_d : sh_dp_q;
    end

    // digit select and segment drive for the current slot
    always_comb begin
        phase = !run_q ? PH_OFF : cnt_q < BLANK_LIM ? PH_BLANK : PH_DRIVE;
        nib   = sh_data_q[{idx_q, 2'b00} +: 4];
`ifdef DIG_LZB_EN
        lzb_ok = idx_q == 3'd0 || |(sh_data_q >> {idx_q, 2'b00});
`else
        lzb_ok = 1'b1;
`endif
        lit        = phase == PH_DRIVE && mask_q[idx_q] && lzb_ok;
        dig_en_d   = lit ? ~(8'b1 << idx_q) : 8'hFF;
        dig_data_d = lit ? {seg, ~sh_dp_q[idx_q]} : 8'hFF;
    end

    // state update; reset wins over a simultaneous write
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q     <= '0;
            sh_data_q  <= '0;
            mask_q     <= DIG_CTRL_RST[7:0];
            dp_q       <= DIG_CTRL_RST[15:8];
            sh_dp_q    <= DIG_CTRL_RST[15:8];
            run_q      <= DIG_CTRL_RST[16];
            cnt_q      <= '0;
            idx_q      <= '0;
            dig_en_q   <= 8'hFF;
            dig_data_q <= 8'hFF;
        end else begin
            data_q     <= data_d;
            sh_data_q  <= sh_data_d;
            mask_q     <= mask_d;
            dp_q       <= dp_d;
            sh_dp_q    <= sh_dp_d;
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            dig_en_q   <= dig_en_d;
            dig_data_q <= dig_data_d;
        end
    end

    assign dig_en   = dig_en_q;
    assign dig_data = dig_data_q;

endmodule

// File: tb/tb_dig_scan_ctrl.sv
// tb_dig_scan_ctrl: scoreboard bench for dig_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2
module tb_dig_scan_ctrl;

    localparam int SD = 8;
    localparam int BC = 2;
`ifdef DIG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        wen = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  dig_en, dig_data;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    dig_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .addr     (addr),
        .wen      (wen),
        .wdata    (wdata),
        .rdata    (rdata),
        .dig_en   (dig_en),
        .dig_data (dig_data)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    // expected {dig_en, dig_data} for frame position pos (slot = pos/SD, cycle = pos%SD)
    function automatic logic [15:0] exp_at(input int pos, input logic [31:0] d,
                                           input logic [7:0] m, input logic [7:0] dp);
        int s;
        int c;
        logic [7:0] en;
        s = pos / SD;
        c = pos % SD;
        if (c < BC || !m[s]) return 16'hFFFF;
        if (LZB && s != 0 && (d >> (4 * s)) == 32'd0) return 16'hFFFF;
        en = 8'hFF;
        en[s] = 1'b0;
        return {en, seg_of(d[4*s +: 4]), ~dp[s]};
    endfunction

    task automatic push_frame(input logic [31:0] d, input logic [7:0] m, input logic [7:0] dp,
                              input int from = 0, input int to = 8 * SD - 1);
        for (int p = from; p <= to; p++) exp_q.push_back(exp_at(p, d, m, dp));
    endtask

    task automatic push_ff(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(16'hFFFF);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // run n cycles, optionally writing before cycle wr_at, comparing outputs against the scoreboard
    task automatic drain(input int n, input string name, input int wr_at = -1,
                         input logic [11:0] wa = '0, input logic [31:0] wd = '0);
        logic [15:0] got;
        logic [15:0] e;
        for (int i = 0; i < n; i++) begin
            if (i == wr_at) begin
                wen = 1'b1;
                addr = wa;
                wdata = wd;
            end
            step();
            wen = 1'b0;
            got = {dig_en, dig_data};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL %s cycle %0d: en/data=%h but scoreboard empty", name, i, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s cycle %0d: en/data=%h expected %h", name, i, got, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if ({dig_en, dig_data} !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_out: got %h expected ffff", {dig_en, dig_data});
        end
        addr = 12'h004;
        #1;
        checks++;
        if (rdata !== 32'h0001_00FF) begin
            failures++;
            $display("FAIL reset_ctrl: got %h expected 000100ff", rdata);
        end
        addr = 12'h000;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 00000000", rdata);
        end
        rst_i = 1'b0;
        push_frame(32'h0, 8'hFF, 8'h00);
        drain(64, "boot");
    endtask

    task automatic test_data_midframe();
        push_frame(32'h0, 8'hFF, 8'h00);
        drain(21, "data_old_a", 20, 12'h000, 32'h1234_5678);
        checks++;
        if (rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL data_readback: got %h expected 12345678", rdata);
        end
        drain(43, "data_old_b");
        push_frame(32'h1234_5678, 8'hFF, 8'h00);
        drain(64, "data_new");
    endtask

    task automatic test_ctrl();
        push_frame(32'h1234_5678, 8'h0F, 8'h00);
        drain(21, "ctrl_cur_a", 20, 12'h004, 32'h0001_010F);
        checks++;
        if (rdata !== 32'h0001_010F) begin
            failures++;
            $display("FAIL ctrl_readback: got %h expected 0001010f", rdata);
        end
        drain(43, "ctrl_cur_b");
        push_frame(32'h1234_5678, 8'h0F, 8'h01);
        drain(64, "ctrl_dp");
    endtask

    task automatic test_run();
        push_frame(32'h1234_5678, 8'h0F, 8'h01, 0, 26);
        push_ff(10);
        drain(37, "run_stop", 26, 12'h004, 32'h0000_010F);
        push_ff(4);
        drain(4, "bad_ofs", 0, 12'h008, 32'hFFFF_FFFF);
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL bad_ofs_read: got %h expected 00000000", rdata);
        end
        addr = 12'h000;
        #1;
        checks++;
        if (rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL bad_ofs_data: got %h expected 12345678", rdata);
        end
        addr = 12'h004;
        #1;
        checks++;
        if (rdata !== 32'h0000_010F) begin
            failures++;
            $display("FAIL bad_ofs_ctrl: got %h expected 0000010f", rdata);
        end
        push_ff(3);
        drain(3, "stopped_data", 0, 12'h000, 32'h8765_4321);
        push_ff(1);
        push_frame(32'h8765_4321, 8'h0F, 8'h01);
        drain(65, "restart", 0, 12'h004, 32'h0001_010F);
    endtask

    task automatic test_frame_end_write();
        push_frame(32'h8765_4321, 8'h0F, 8'h01);
        drain(64, "fe_old", 63, 12'h000, 32'h0000_0A05);
        push_frame(32'h0000_0A05, 8'h0F, 8'h01);
        drain(64, "fe_new");
    endtask

    task automatic test_lzb();
        push_frame(32'h0000_0A05, 8'hFF, 8'h01);
        drain(64, "lzb_dp", 0, 12'h004, 32'h0001_00FF);
        push_frame(32'h0000_0A05, 8'hFF, 8'h00);
        drain(64, "lzb_plain");
    endtask

    task automatic test_reset_midslot();
        push_frame(32'h0000_0A05, 8'hFF, 8'h00, 0, 12);
        drain(13, "pre_rst");
        rst_i = 1'b1;
        wen = 1'b1;
        addr = 12'h000;
        wdata = 32'hDEAD_BEEF;
        step();
        wen = 1'b0;
        checks++;
        if ({dig_en, dig_data} !== 16'hFFFF) begin
            failures++;
            $display("FAIL midrst_out: got %h expected ffff", {dig_en, dig_data});
        end
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL midrst_data: got %h expected 00000000", rdata);
        end
        addr = 12'h004;
        #1;
        checks++;
        if (rdata !== 32'h0001_00FF) begin
            failures++;
            $display("FAIL midrst_ctrl: got %h expected 000100ff", rdata);
        end
        rst_i = 1'b0;
        push_frame(32'h0, 8'hFF, 8'h00, 0, 10);
        drain(11, "post_rst");
    endtask

    initial begin
        test_reset();
        test_data_midframe();
        test_ctrl();
        test_run();
        test_frame_end_write();
        test_lzb();
        test_reset_midslot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
